// File: rtl/xr16_dma_pkg.sv
// Shared constants and FSM state encoding for the xr16 DMA arbiter.
package xr16_dma_pkg;

  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_CW    = 2;
  localparam int unsigned DEF_PW    = 2;
  localparam int unsigned DEF_BURST = 4;

  // Burst counter width; covers BURST up to 15.
  localparam int unsigned BW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set mask bit after 'last', wrapping.
module rr_pick
  import xr16_dma_pkg::*;
#(
  parameter int unsigned NCH = DEF_NCH,
  parameter int unsigned CW  = DEF_CW
) (
  input  logic [NCH-1:0] mask,
  input  logic [CW-1:0]  last,
  output logic           valid,
  output logic [CW-1:0]  idx
);

  logic [CW-1:0] cand;

  // Scan from farthest to nearest so the nearest candidate after 'last' wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = int'(NCH); k >= 1; k--) begin
      cand = CW'((int'(last) + k) % int'(NCH));
      if (mask[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/xr16_dma_arb.sv
// Round-robin DMA scheduler sharing the xr16 core's single DMA slot.
module xr16_dma_arb
  import xr16_dma_pkg::*;
#(
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned CW    = DEF_CW,
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned BURST = DEF_BURST
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] zreq,
  input  logic           dma,
  input  logic           mem_ce,
  output logic           dma_req,
  output logic           zerodma,
  output logic [CW-1:0]  gnt_ch,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] ovf
);

  localparam logic [PW-1:0] CNT_MAX   = {PW{1'b1}};
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST);

  arb_state_e     state, state_nxt;
  logic [PW-1:0]  cnt     [NCH];
  logic [PW-1:0]  cnt_nxt [NCH];
  logic [NCH-1:0] zf, zf_nxt, pend, pend_nxt, fin, drop, gnt_oh, pick_mask;
  logic [BW-1:0]  bcnt, bcnt_nxt, bcnt_inc;
  logic [CW-1:0]  last, last_nxt, gnt_nxt, pick_idx;
  logic           dreq_nxt, zd_nxt, pick_vld, done;

  // A transfer completes only while we own the slot and the core is not wait-stated.
  assign done      = (state == ST_REQ) & dma & mem_ce;
  assign gnt_oh    = NCH'(1) << gnt_ch;
  assign fin       = done ? gnt_oh : '0;
  assign bcnt_inc  = bcnt + BW'(1);
  // Back-to-back picks see the post-completion counts; idle picks see registered counts.
  assign pick_mask = done ? pend_nxt : pend;

  rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .mask  (pick_mask),
    .last  (last),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Per-channel pending counters, zero flags and overflow detection.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      cnt_nxt[i] = cnt[i];
      drop[i]    = 1'b0;
      if (req[i] && !fin[i]) begin
        if (cnt[i] == CNT_MAX) drop[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + PW'(1);
      end else if (fin[i] && !req[i]) begin
        cnt_nxt[i] = cnt[i] - PW'(1);
      end
      pend[i]     = (cnt[i] != '0);
      pend_nxt[i] = (cnt_nxt[i] != '0);
    end
    zf_nxt = (zf & ~fin) | (req & zreq);
  end

  // Next-state and next-output logic for the IDLE/REQ/GAP scheduler.
  always_comb begin
    state_nxt = state;
    dreq_nxt  = dma_req;
    zd_nxt    = zerodma;
    gnt_nxt   = gnt_ch;
    last_nxt  = last;
    bcnt_nxt  = bcnt;
    case (state)
      ST_IDLE, ST_GAP: begin
        bcnt_nxt = '0;
        if (pick_vld) begin
          state_nxt = ST_REQ;
          dreq_nxt  = 1'b1;
          zd_nxt    = zf[pick_idx];
          gnt_nxt   = pick_idx;
          last_nxt  = pick_idx;
        end else begin
          state_nxt = ST_IDLE;
          dreq_nxt  = 1'b0;
          zd_nxt    = 1'b0;
        end
      end
      ST_REQ: begin
        if (done) begin
          if (bcnt_inc == BURST_LIM) begin
            state_nxt = ST_GAP;
            dreq_nxt  = 1'b0;
            zd_nxt    = 1'b0;
            bcnt_nxt  = '0;
          end else if (pick_vld) begin
            bcnt_nxt  = bcnt_inc;
            zd_nxt    = zf_nxt[pick_idx];
            gnt_nxt   = pick_idx;
            last_nxt  = pick_idx;
          end else begin
            state_nxt = ST_IDLE;
            dreq_nxt  = 1'b0;
            zd_nxt    = 1'b0;
            bcnt_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        dreq_nxt  = 1'b0;
        zd_nxt    = 1'b0;
        bcnt_nxt  = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Registered outputs, counters and arbitration bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NCH); i++) cnt[i] <= '0;
      zf      <= '0;
      ovf     <= '0;
      ack     <= '0;
      dma_req <= 1'b0;
      zerodma <= 1'b0;
      gnt_ch  <= '0;
      last    <= CW'(NCH - 1);
      bcnt    <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) cnt[i] <= cnt_nxt[i];
      zf      <= zf_nxt;
      ovf     <= ovf | drop;
      ack     <= fin;
      dma_req <= dreq_nxt;
      zerodma <= zd_nxt;
      gnt_ch  <= gnt_nxt;
      last    <= last_nxt;
      bcnt    <= bcnt_nxt;
    end
  end

endmodule

// File: tb/tb_xr16_dma_arb.sv
// Self-checking bench for xr16_dma_arb: transaction-level model plus directed scenarios.
module tb_xr16_dma_arb;

  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int PW    = 2;
  localparam int BURST = 4;
  localparam int CMAX  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] zreq = '0;
  logic           dma = 1'b0;
  logic           mem_ce = 1'b0;
  logic           dma_req, zerodma;
  logic [CW-1:0]  gnt_ch;
  logic [NCH-1:0] ack, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  xr16_dma_arb #(.NCH(NCH), .CW(CW), .PW(PW), .BURST(BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .zreq    (zreq),
    .dma     (dma),
    .mem_ce  (mem_ce),
    .dma_req (dma_req),
    .zerodma (zerodma),
    .gnt_ch  (gnt_ch),
    .ack     (ack),
    .ovf     (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int             m_cnt [NCH];
  bit [NCH-1:0]   m_zf, m_ovf, m_ack;
  bit             m_busy, m_zd;
  int             m_gnt = 0;
  int             m_last = NCH - 1;
  int             m_burst = 0;

  function automatic int pick(input bit [NCH-1:0] mask, input int last);
    for (int k = 1; k <= NCH; k++)
      if (mask[(last + k) % NCH]) return (last + k) % NCH;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit           m_done;
    bit [NCH-1:0] old_m, new_m, old_zf;
    int           p;
    if (!rst) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_zf = '0; m_ovf = '0; m_ack = '0;
      m_busy = 1'b0; m_zd = 1'b0; m_gnt = 0; m_last = NCH - 1; m_burst = 0;
    end else begin
      m_done = m_busy && dma && mem_ce;
      old_zf = m_zf;
      for (int i = 0; i < NCH; i++) old_m[i] = (m_cnt[i] > 0);
      for (int i = 0; i < NCH; i++) begin
        if (!(req[i] && m_done && m_gnt == i)) begin
          if (req[i]) begin
            if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
            else                  m_cnt[i]++;
          end else if (m_done && m_gnt == i) begin
            m_cnt[i]--;
          end
        end
        if (m_done && m_gnt == i) m_zf[i] = 1'b0;
        if (req[i] && zreq[i])    m_zf[i] = 1'b1;
        new_m[i] = (m_cnt[i] > 0);
      end
      m_ack = '0;
      if (m_done) m_ack[m_gnt] = 1'b1;
      if (!m_busy) begin
        m_burst = 0;
        p = pick(old_m, m_last);
        if (p >= 0) begin
          m_busy = 1'b1; m_gnt = p; m_last = p; m_zd = old_zf[p];
        end else begin
          m_zd = 1'b0;
        end
      end else if (m_done) begin
        m_burst++;
        if (m_burst == BURST) begin
          m_busy = 1'b0; m_zd = 1'b0; m_burst = 0;
        end else begin
          p = pick(new_m, m_last);
          if (p >= 0) begin
            m_gnt = p; m_last = p; m_zd = m_zf[p];
          end else begin
            m_busy = 1'b0; m_zd = 1'b0; m_burst = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("dma_req", 32'(dma_req), 32'(m_busy));
      chk("zerodma", 32'(zerodma), 32'(m_zd));
      chk("ack",     32'(ack),     32'(m_ack));
      chk("ovf",     32'(ovf),     32'(m_ovf));
      if (m_busy) chk("gnt_ch", 32'(gnt_ch), 32'(m_gnt));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    req = '0; zreq = '0; dma = 1'b0; mem_ce = 1'b0;
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
  endtask

  initial begin : main
    logic [7:0] pat;
    int         acks;

    // Reset state.
    step(1);
    armed = 1'b1;
    step(1);
    chk("rst_dma_req", 32'(dma_req), 32'd0);
    chk("rst_zerodma", 32'(zerodma), 32'd0);
    chk("rst_gnt_ch",  32'(gnt_ch),  32'd0);
    chk("rst_ack",     32'(ack),     32'd0);
    chk("rst_ovf",     32'(ovf),     32'd0);
    rst = 1'b1;
    step(1);

    // Single request on channel 2.
    req = 4'b0100; step(1);
    req = 4'b0000; step(1);
    chk("single_dreq", 32'(dma_req), 32'd1);
    chk("single_gnt",  32'(gnt_ch),  32'd2);
    step(1);
    chk("single_noack", 32'(ack), 32'd0);
    step(1);
    dma = 1'b1; mem_ce = 1'b1;
    step(1);
    dma = 1'b0; mem_ce = 1'b0;
    chk("single_ack",  32'(ack),     32'b0100);
    chk("single_idle", 32'(dma_req), 32'd0);
    step(1);
    chk("single_ack_end", 32'(ack), 32'd0);

    // Round robin across channels 0,1,3; dma held high before grant is ignored.
    do_reset();
    req = 4'b1011; step(1);
    req = 4'b0000; dma = 1'b1; mem_ce = 1'b1;
    step(1);
    chk("rr_g0", 32'(gnt_ch), 32'd0);
    chk("rr_d0", 32'(dma_req), 32'd1);
    step(1);
    chk("rr_g1", 32'(gnt_ch), 32'd1);
    chk("rr_a0", 32'(ack), 32'b0001);
    step(1);
    chk("rr_g3", 32'(gnt_ch), 32'd3);
    chk("rr_a1", 32'(ack), 32'b0010);
    chk("rr_d2", 32'(dma_req), 32'd1);
    step(1);
    chk("rr_a3",   32'(ack), 32'b1000);
    chk("rr_idle", 32'(dma_req), 32'd0);
    dma = 1'b0; mem_ce = 1'b0;
    step(1);

    // Burst limit: 3+3 requests, completion every cycle.
    do_reset();
    req = 4'b0011; step(3);
    req = 4'b0000; dma = 1'b1; mem_ce = 1'b1;
    pat = '0; acks = 0;
    for (int k = 0; k < 8; k++) begin
      pat[7-k] = dma_req;
      acks += $countones(ack);
      step(1);
    end
    chk("burst_pattern", 32'(pat), 32'b1111_0110);
    chk("burst_acks",    32'(acks), 32'd6);
    dma = 1'b0; mem_ce = 1'b0;
    step(1);

    // zerodma on the first grant only.
    do_reset();
    req = 4'b0010; zreq = 4'b0010; step(1);
    zreq = 4'b0000; step(1);
    req = 4'b0000;
    chk("zd_first_gnt", 32'(gnt_ch), 32'd1);
    chk("zd_first",     32'(zerodma), 32'd1);
    dma = 1'b1; mem_ce = 1'b1;
    step(1);
    chk("zd_second",      32'(zerodma), 32'd0);
    chk("zd_second_dreq", 32'(dma_req), 32'd1);
    chk("zd_ack1",        32'(ack), 32'b0010);
    step(1);
    chk("zd_ack2", 32'(ack), 32'b0010);
    chk("zd_idle", 32'(dma_req), 32'd0);
    dma = 1'b0; mem_ce = 1'b0;
    step(1);

    // Overflow, then req coincident with completion on channel 0.
    do_reset();
    req = 4'b0001; step(4);
    chk("ovf_set",  32'(ovf), 32'b0001);
    chk("ovf_dreq", 32'(dma_req), 32'd1);
    dma = 1'b1; mem_ce = 1'b1;
    step(1);
    req = 4'b0000;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      acks += $countones(ack);
      step(1);
    end
    chk("ovf_same_cycle_acks", 32'(acks), 32'd4);
    chk("ovf_sticky",          32'(ovf), 32'b0001);
    dma = 1'b0; mem_ce = 1'b0;
    step(1);

    // Wait states, then asynchronous reset mid-transfer.
    do_reset();
    req = 4'b1000; step(1);
    req = 4'b0000; step(1);
    chk("ws_gnt", 32'(gnt_ch), 32'd3);
    dma = 1'b1; mem_ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("ws_noack", 32'(ack), 32'd0);
      chk("ws_hold",  32'(dma_req), 32'd1);
    end
    rst = 1'b0;
    #1;
    chk("async_rst_dreq", 32'(dma_req), 32'd0);
    chk("async_rst_gnt",  32'(gnt_ch),  32'd0);
    step(1);
    rst = 1'b1; dma = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("post_rst_idle", 32'(dma_req), 32'd0);
    end
    req = 4'b0001; step(1);
    req = 4'b0000; step(1);
    chk("post_rst_regrant", 32'(dma_req), 32'd1);
    chk("post_rst_gnt",     32'(gnt_ch),  32'd0);
    step(2);

    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xr16_dma_arb.md
# xr16_dma_arb

Round-robin DMA scheduler that shares the xr16 core's single DMA slot among NCH on-chip requesters (video refresh, serial, user channels). It queues per-channel transfer requests, drives the core's `dma_req`/`zerodma` inputs, and watches the core's `dma`/`mem_ce` outputs to detect each completed transfer. It then reports the completion to the owning channel. A burst limit guarantees the core forward progress between DMA runs.

## Interface
- `NCH`, 4: number of requesting channels (2..4).
- `CW`, 2: channel-number width, log2(NCH).
- `PW`, 2: pending-counter width; each channel holds up to 2^PW-1 outstanding requests.
- `BURST`, 4: maximum back-to-back DMA transfers before a forced one-cycle gap (1..15).

- `clk`  in  1  global clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NCH  per-channel one-cycle pulse; posts one transfer request.
- `zreq`  in  NCH  qualifies `req`; that channel's next transfer restarts the DMA pointer.
- `dma`  in  1  from core; the current access is a DMA transfer.
- `mem_ce`  in  1  from core; the current memory access completes this cycle.
- `dma_req`  out  1  to core; DMA transfer requested (registered).
- `zerodma`  out  1  to core; zero the DMA pointer before this transfer (registered).
- `gnt_ch`  out  CW  channel that owns the requested or in-flight transfer.
- `ack`  out  NCH  one-cycle pulse; transfer for that channel completed.
- `ovf`  out  NCH  sticky; a request was dropped because the counter was full.

## Operation
- **Per channel:** pending counter `cnt[i]` and zero flag `zf[i]`.
  - `req[i]` increments `cnt[i]`.
  - `req[i] & zreq[i]` sets `zf[i]`.
- **States:** IDLE, REQ, GAP.
- **IDLE**
  - Stays in IDLE while every `cnt` is 0.
  - When any `cnt` is nonzero, picks a channel round-robin, starting at the channel after the last granted one (channel 0 after reset).
  - Loads `gnt_ch` and sets `dma_req=1` and `zerodma=zf[gnt]`, then goes to REQ.
- **REQ**
  - Holds `dma_req`, `zerodma` and `gnt_ch` stable.
  - Completion is a cycle with `dma & mem_ce`. On completion:
    - pulse `ack[gnt_ch]`;
    - decrement `cnt[gnt_ch]`;
    - clear `zf[gnt_ch]`;
    - increment the burst counter.
  - After a completion, the next state is:
    - GAP if the burst counter equals BURST;
    - otherwise REQ with a new round-robin pick if any `cnt` stays nonzero;
    - otherwise IDLE.
  - `dma_req` stays 1 across back-to-back transfers.
- **GAP**
  - `dma_req=0` for exactly one cycle; the burst counter clears.
  - Then behaves as IDLE (re-arbitrates immediately).
  - The burst counter also clears on entry to IDLE.
- **Same-cycle `req[i]` and completion for i:** `cnt[i]` is unchanged. The round-robin pick uses the post-update counts.
- **`req[i]` with `cnt[i]` at maximum:** the request is dropped and `ovf[i]` is set; `ovf` clears only on reset.
- **Completion with `dma=1`, `mem_ce=0`:** not a completion (core is wait-stated by `rdy`).
- **`dma` while `dma_req=0`:** ignored; no ack and no count change.
- **Reset values** (asynchronous, mid-transfer included): all counters, flags and `ovf` cleared; `dma_req=0`, `zerodma=0`, `gnt_ch=0`, `ack=0`; state IDLE; round-robin pointer points at channel 0.

## Timing
- `req` pulse in cycle t: `cnt` is updated at edge t+1. `dma_req` rises at edge t+2 when the arbiter was IDLE.
- `ack` rises at the edge following the completion cycle and lasts one cycle.
- Back-to-back transfers: zero idle cycles between them, up to BURST transfers.
- After BURST transfers, `dma_req` is low for exactly one cycle.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- **Package `xr16_dma_pkg`:** state encoding (IDLE/REQ/GAP), default NCH/CW/PW/BURST constants.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs are a pending mask and the last-grant index; outputs are a valid flag and the next index. It is instantiated once.
- **Top level:** counters, flags, burst counter and FSM.

## Test plan
- **Single request:** `req[2]` pulse at t -> `dma_req=1`, `gnt_ch=2` at t+2. Apply `dma & mem_ce` at t+4 -> `ack[2]` at t+5, then `dma_req=0` and IDLE.
- **Round robin:** `req` on channels 0, 1 and 3 in one cycle -> grants in order 0, 1, 3, with `dma_req` high continuously and three acks.
- **Burst limit:** with BURST=4, channel 0 holds 3 and channel 1 holds 3 requests, completion every cycle -> `dma_req` drops for exactly one cycle after the 4th ack, then 2 more transfers.
- **zerodma:** `req[1] & zreq[1]`, then plain `req[1]` -> first grant has `zerodma=1`, second has `zerodma=0`.
- **Overflow and same-cycle update:**
  - 4 `req[0]` pulses with no completions -> `cnt[0]=3`, `ovf[0]=1` stays set.
  - `req[0]` coincident with channel-0 completion -> count unchanged.
- **Wait states and reset:**
  - `dma=1` with `mem_ce=0` for 3 cycles -> no ack.
  - Assert `rst` low during REQ -> `dma_req=0` and all counts 0 immediately; nothing is granted after release until a new `req`.
